// File: rtl/rs_pkg.sv
// Shared types and default sizing for the reservation-station wakeup table.
// Optional feature macro used by rs_wakeup_table: RS_CDB_BYPASS_EN.
package rs_pkg;

    localparam int RS_ENTRIES   = 16;
    localparam int RS_ISSUE_W   = 3;
    localparam int RS_TAG_W     = 6;
    localparam int RS_PAYLOAD_W = 32;
    localparam int RS_CDB_W     = 2;
    localparam int RS_IDX_W     = $clog2(RS_ENTRIES);

    typedef struct packed {
        logic                    valid;
        logic                    rdy1;
        logic                    rdy2;
        logic [RS_TAG_W-1:0]     src1_tag;
        logic [RS_TAG_W-1:0]     src2_tag;
        logic [RS_TAG_W-1:0]     dest_tag;
        logic [RS_PAYLOAD_W-1:0] payload;
    } rs_entry_t;

    // Isolates the lowest set bit; turns any grant vector into a one-hot pick.
    function automatic logic [RS_ENTRIES-1:0] lowest_one(input logic [RS_ENTRIES-1:0] v);
        return v & (~v + RS_ENTRIES'(1));
    endfunction

endpackage

// File: rtl/rs_tag_match.sv
// Compares one source tag against every valid CDB broadcast lane.
module rs_tag_match
    import rs_pkg::*;
#(
    parameter int TAG_W = RS_TAG_W,
    parameter int CDB_W = RS_CDB_W
) (
    input  logic [TAG_W-1:0]       tag,
    input  logic [CDB_W-1:0]       cdb_valid,
    input  logic [CDB_W*TAG_W-1:0] cdb_tag,
    output logic                   hit
);

    // Any valid lane carrying this tag counts as a hit.
    always_comb begin
        hit = 1'b0;
        for (int l = 0; l < CDB_W; l++) begin
            if (cdb_valid[l] && (cdb_tag[l*TAG_W +: TAG_W] == tag)) begin
                hit = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rs_wakeup_table.sv
// Reservation-station entry storage: dispatch into the lowest free entry,
// CDB wakeup of source operands, request/grant exchange with the issue
// selector and registered issue slots.
// Optional feature macro: RS_CDB_BYPASS_EN (same-cycle CDB match feeds req).
module rs_wakeup_table
    import rs_pkg::*;
#(
    parameter int ENTRIES   = RS_ENTRIES,
    parameter int ISSUE_W   = RS_ISSUE_W,
    parameter int TAG_W     = RS_TAG_W,
    parameter int PAYLOAD_W = RS_PAYLOAD_W,
    parameter int CDB_W     = RS_CDB_W
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           disp_valid,
    output logic                           disp_ready,
    input  logic [TAG_W-1:0]               disp_src1_tag,
    input  logic [TAG_W-1:0]               disp_src2_tag,
    input  logic                           disp_src1_rdy,
    input  logic                           disp_src2_rdy,
    input  logic [TAG_W-1:0]               disp_dest_tag,
    input  logic [PAYLOAD_W-1:0]           disp_payload,
    input  logic [CDB_W-1:0]               cdb_valid,
    input  logic [CDB_W*TAG_W-1:0]         cdb_tag,
    output logic                           sel_en,
    output logic [ENTRIES-1:0]             req,
    input  logic [ENTRIES*ISSUE_W-1:0]     gnt_bus,
    output logic [ISSUE_W-1:0]             iss_valid,
    output logic [ISSUE_W*TAG_W-1:0]       iss_dest_tag,
    output logic [ISSUE_W*PAYLOAD_W-1:0]   iss_payload,
    output logic [$clog2(ENTRIES+1)-1:0]   free_count
);

    localparam int CNT_W = $clog2(ENTRIES + 1);

    rs_entry_t              ent_q [ENTRIES];
    logic [ENTRIES-1:0]     valid_vec;
    logic [ENTRIES-1:0]     hit1;
    logic [ENTRIES-1:0]     hit2;
    logic [ENTRIES-1:0]     req_int;
    logic [ENTRIES-1:0]     issue_mask;
    logic [ENTRIES-1:0]     gnt_slot [ISSUE_W];
    logic [ENTRIES-1:0]     gnt_eff  [ISSUE_W];
    logic [TAG_W-1:0]       slot_dest    [ISSUE_W];
    logic [PAYLOAD_W-1:0]   slot_payload [ISSUE_W];
    logic [ISSUE_W-1:0]     iss_valid_q;
    logic [TAG_W-1:0]       iss_dest_q    [ISSUE_W];
    logic [PAYLOAD_W-1:0]   iss_payload_q [ISSUE_W];
    logic [RS_IDX_W-1:0]    alloc_idx;
    logic                   disp_hit1;
    logic                   disp_hit2;
    logic                   do_disp;

    // Two tag comparators per entry for wakeup, two more for the dispatch port.
    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        assign valid_vec[i] = ent_q[i].valid;

        rs_tag_match #(.TAG_W(TAG_W), .CDB_W(CDB_W)) u_src1_match (
            .tag       (ent_q[i].src1_tag),
            .cdb_valid (cdb_valid),
            .cdb_tag   (cdb_tag),
            .hit       (hit1[i])
        );

        rs_tag_match #(.TAG_W(TAG_W), .CDB_W(CDB_W)) u_src2_match (
            .tag       (ent_q[i].src2_tag),
            .cdb_valid (cdb_valid),
            .cdb_tag   (cdb_tag),
            .hit       (hit2[i])
        );
    end

    rs_tag_match #(.TAG_W(TAG_W), .CDB_W(CDB_W)) u_disp_src1_match (
        .tag       (disp_src1_tag),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .hit       (disp_hit1)
    );

    rs_tag_match #(.TAG_W(TAG_W), .CDB_W(CDB_W)) u_disp_src2_match (
        .tag       (disp_src2_tag),
        .cdb_valid (cdb_valid),
        .cdb_tag   (cdb_tag),
        .hit       (disp_hit2)
    );

    // Issue requests: registered readiness, optionally widened by this cycle's CDB hits.
    always_comb begin
        req_int = '0;
        for (int i = 0; i < ENTRIES; i++) begin
`ifdef RS_CDB_BYPASS_EN
            req_int[i] = ent_q[i].valid & (ent_q[i].rdy1 | hit1[i]) & (ent_q[i].rdy2 | hit2[i]);
`else
            req_int[i] = ent_q[i].valid & ent_q[i].rdy1 & ent_q[i].rdy2;
`endif
        end
    end

    assign req    = req_int;
    assign sel_en = reset & ~flush;

    for (genvar s = 0; s < ISSUE_W; s++) begin : g_slot_split
        assign gnt_slot[s] = gnt_bus[s*ENTRIES +: ENTRIES];
    end

    // Effective grants: masked by req and enable; an entry already taken by a
    // lower slot is removed, and a malformed multi-hot slot keeps its lowest bit.
    always_comb begin : grant_pick
        logic [ENTRIES-1:0] cand;
        logic [ENTRIES-1:0] claimed;
        claimed = '0;
        cand    = '0;
        for (int s = 0; s < ISSUE_W; s++) begin
            cand       = gnt_slot[s] & req_int & {ENTRIES{sel_en}} & ~claimed;
            gnt_eff[s] = lowest_one(cand);
            claimed    = claimed | gnt_eff[s];
        end
        issue_mask = claimed;
    end

    // One-hot read mux from the entry array into each issue slot.
    always_comb begin
        for (int s = 0; s < ISSUE_W; s++) begin
            slot_dest[s]    = '0;
            slot_payload[s] = '0;
            for (int i = 0; i < ENTRIES; i++) begin
                if (gnt_eff[s][i]) begin
                    slot_dest[s]    = ent_q[i].dest_tag;
                    slot_payload[s] = ent_q[i].payload;
                end
            end
        end
    end

    // Lowest free entry from registered valid bits only, so an entry being
    // issued this cycle is never picked for the incoming dispatch.
    always_comb begin
        alloc_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (!ent_q[i].valid) begin
                alloc_idx = RS_IDX_W'(i);
            end
        end
    end

    // Free-entry population count.
    always_comb begin
        free_count = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            free_count = free_count + CNT_W'(!ent_q[i].valid);
        end
    end

    assign disp_ready = ~&valid_vec;
    assign do_disp    = disp_valid & disp_ready & ~flush;

    // Entry array and issue slots; reset beats flush, flush beats dispatch and issue.
    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ent_q[i] <= '0;
            end
            iss_valid_q <= '0;
            for (int s = 0; s < ISSUE_W; s++) begin
                iss_dest_q[s]    <= '0;
                iss_payload_q[s] <= '0;
            end
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ent_q[i].valid <= 1'b0;
            end
            iss_valid_q <= '0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (issue_mask[i]) begin
                    ent_q[i].valid <= 1'b0;
                end else if (ent_q[i].valid) begin
                    if (hit1[i]) ent_q[i].rdy1 <= 1'b1;
                    if (hit2[i]) ent_q[i].rdy2 <= 1'b1;
                end
            end
            if (do_disp) begin
                ent_q[alloc_idx] <= '{valid:    1'b1,
                                      rdy1:     disp_src1_rdy | disp_hit1,
                                      rdy2:     disp_src2_rdy | disp_hit2,
                                      src1_tag: disp_src1_tag,
                                      src2_tag: disp_src2_tag,
                                      dest_tag: disp_dest_tag,
                                      payload:  disp_payload};
            end
            for (int s = 0; s < ISSUE_W; s++) begin
                iss_valid_q[s] <= |gnt_eff[s];
                if (|gnt_eff[s]) begin
                    iss_dest_q[s]    <= slot_dest[s];
                    iss_payload_q[s] <= slot_payload[s];
                end
            end
        end
    end

    assign iss_valid = iss_valid_q;

    for (genvar s = 0; s < ISSUE_W; s++) begin : g_slot_out
        assign iss_dest_tag[s*TAG_W +: TAG_W]         = iss_dest_q[s];
        assign iss_payload[s*PAYLOAD_W +: PAYLOAD_W]  = iss_payload_q[s];
    end

`ifndef SYNTHESIS
    // Grant-bus sanity; skipped while disabled because the selector drives all-ones in reset.
    always @(posedge clock) begin
        if (sel_en) begin
            for (int s = 0; s < ISSUE_W; s++) begin
                assert ($onehot0(gnt_slot[s]))
                    else $warning("rs_wakeup_table: slot %0d grant is not one-hot", s);
                for (int t = s + 1; t < ISSUE_W; t++) begin
                    assert ((gnt_slot[s] & gnt_slot[t]) == '0)
                        else $warning("rs_wakeup_table: entry granted in slots %0d and %0d", s, t);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_rs_wakeup_table.sv
// Bench for rs_wakeup_table: directed scenarios with a queue of expected
// issue-slot contents that a monitor pops whenever a slot goes valid.
module tb_rs_wakeup_table;

    localparam int ENTRIES   = 16;
    localparam int ISSUE_W   = 3;
    localparam int TAG_W     = 6;
    localparam int PAYLOAD_W = 32;
    localparam int CDB_W     = 2;

    logic                         clock = 1'b0;
    logic                         reset = 1'b0;
    logic                         flush = 1'b0;
    logic                         disp_valid = 1'b0;
    logic                         disp_ready;
    logic [TAG_W-1:0]             disp_src1_tag = '0;
    logic [TAG_W-1:0]             disp_src2_tag = '0;
    logic                         disp_src1_rdy = 1'b0;
    logic                         disp_src2_rdy = 1'b0;
    logic [TAG_W-1:0]             disp_dest_tag = '0;
    logic [PAYLOAD_W-1:0]         disp_payload = '0;
    logic [CDB_W-1:0]             cdb_valid = '0;
    logic [CDB_W*TAG_W-1:0]       cdb_tag = '0;
    logic                         sel_en;
    logic [ENTRIES-1:0]           req;
    logic [ENTRIES*ISSUE_W-1:0]   gnt_bus = '0;
    logic [ISSUE_W-1:0]           iss_valid;
    logic [ISSUE_W*TAG_W-1:0]     iss_dest_tag;
    logic [ISSUE_W*PAYLOAD_W-1:0] iss_payload;
    logic [$clog2(ENTRIES+1)-1:0] free_count;

    typedef struct {
        int                   slot;
        logic [TAG_W-1:0]     dest;
        logic [PAYLOAD_W-1:0] payload;
    } exp_t;

    exp_t                 exp_q[$];
    exp_t                 mon_e;
    logic [TAG_W-1:0]     mdl_dest [ENTRIES];
    logic [PAYLOAD_W-1:0] mdl_pay  [ENTRIES];
    int                   vectors = 0;
    int                   miscompares = 0;

    rs_wakeup_table dut (
        .clock         (clock),
        .reset         (reset),
        .flush         (flush),
        .disp_valid    (disp_valid),
        .disp_ready    (disp_ready),
        .disp_src1_tag (disp_src1_tag),
        .disp_src2_tag (disp_src2_tag),
        .disp_src1_rdy (disp_src1_rdy),
        .disp_src2_rdy (disp_src2_rdy),
        .disp_dest_tag (disp_dest_tag),
        .disp_payload  (disp_payload),
        .cdb_valid     (cdb_valid),
        .cdb_tag       (cdb_tag),
        .sel_en        (sel_en),
        .req           (req),
        .gnt_bus       (gnt_bus),
        .iss_valid     (iss_valid),
        .iss_dest_tag  (iss_dest_tag),
        .iss_payload   (iss_payload),
        .free_count    (free_count)
    );

    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got unfinished run, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard monitor: every valid issue slot must match the oldest expectation.
    always @(posedge clock) begin
        #2;
        for (int s = 0; s < ISSUE_W; s++) begin
            if (iss_valid[s] === 1'b1) begin
                vectors++;
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL issue_unexpected: slot %0d got dest %0d payload %h, expected no issue",
                             s, iss_dest_tag[s*TAG_W +: TAG_W], iss_payload[s*PAYLOAD_W +: PAYLOAD_W]);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e.slot != s || iss_dest_tag[s*TAG_W +: TAG_W] !== mon_e.dest ||
                        iss_payload[s*PAYLOAD_W +: PAYLOAD_W] !== mon_e.payload) begin
                        miscompares++;
                        $display("FAIL issue_data: got slot %0d dest %0d payload %h, expected slot %0d dest %0d payload %h",
                                 s, iss_dest_tag[s*TAG_W +: TAG_W], iss_payload[s*PAYLOAD_W +: PAYLOAD_W],
                                 mon_e.slot, mon_e.dest, mon_e.payload);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        disp_valid = 1'b0;
        flush      = 1'b0;
        cdb_valid  = '0;
        cdb_tag    = '0;
        gnt_bus    = '0;
    endtask

    // Drives a dispatch; idx >= 0 records what the bench expects to land in that entry.
    task automatic set_disp(input logic [TAG_W-1:0] s1, input logic r1,
                            input logic [TAG_W-1:0] s2, input logic r2,
                            input logic [TAG_W-1:0] dest, input logic [PAYLOAD_W-1:0] pay,
                            input int idx);
        disp_valid    = 1'b1;
        disp_src1_tag = s1;
        disp_src1_rdy = r1;
        disp_src2_tag = s2;
        disp_src2_rdy = r2;
        disp_dest_tag = dest;
        disp_payload  = pay;
        if (idx >= 0) begin
            mdl_dest[idx] = dest;
            mdl_pay[idx]  = pay;
        end
    endtask

    task automatic grant(input int s, input int e, input bit expect_issue);
        exp_t x;
        gnt_bus[s*ENTRIES + e] = 1'b1;
        if (expect_issue) begin
            x.slot    = s;
            x.dest    = mdl_dest[e];
            x.payload = mdl_pay[e];
            exp_q.push_back(x);
        end
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset         = 1'b0;
        gnt_bus       = '1;
        disp_valid    = 1'b1;
        disp_src1_rdy = 1'b1;
        disp_src2_rdy = 1'b1;
        step();
        vectors++;
        if (sel_en !== 1'b0) begin miscompares++; $display("FAIL reset_sel_en: got %b expected 0", sel_en); end
        step();
        reset = 1'b1;
        idle_inputs();
        #1;
        vectors++;
        if (req !== 16'h0) begin miscompares++; $display("FAIL reset_req: got %h expected 0000", req); end
        vectors++;
        if (free_count !== 5'd16) begin miscompares++; $display("FAIL reset_free_count: got %0d expected 16", free_count); end
        vectors++;
        if (disp_ready !== 1'b1) begin miscompares++; $display("FAIL reset_disp_ready: got %b expected 1", disp_ready); end
        vectors++;
        if (iss_valid !== 3'b000) begin miscompares++; $display("FAIL reset_iss_valid: got %b expected 000", iss_valid); end
        vectors++;
        if (iss_dest_tag !== '0 || iss_payload !== '0) begin
            miscompares++;
            $display("FAIL reset_iss_data: got dest %h payload %h expected zeros", iss_dest_tag, iss_payload);
        end
        vectors++;
        if (sel_en !== 1'b1) begin miscompares++; $display("FAIL reset_sel_en_release: got %b expected 1", sel_en); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < ENTRIES; i++) begin
            set_disp(6'(i), 1'b1, 6'(i + 16), 1'b1, 6'(i + 32), 32'hF000_0000 | 32'(i), i);
            step();
            vectors++;
            if (free_count !== 5'(15 - i)) begin
                miscompares++;
                $display("FAIL fill_free_count[%0d]: got %0d expected %0d", i, free_count, 15 - i);
            end
        end
        disp_valid = 1'b0;
        vectors++;
        if (disp_ready !== 1'b0) begin miscompares++; $display("FAIL full_disp_ready: got %b expected 0", disp_ready); end
        vectors++;
        if (req !== 16'hFFFF) begin miscompares++; $display("FAIL full_req: got %h expected ffff", req); end
        set_disp(6'd1, 1'b1, 6'd2, 1'b1, 6'd63, 32'hDEAD_BEEF, -1);
        step();
        disp_valid = 1'b0;
        vectors++;
        if (free_count !== 5'd0) begin miscompares++; $display("FAIL full_drop_free_count: got %0d expected 0", free_count); end
        for (int k = 0; k < ENTRIES; k += ISSUE_W) begin
            gnt_bus = '0;
            for (int s = 0; s < ISSUE_W; s++) begin
                if (k + s < ENTRIES) grant(s, k + s, 1'b1);
            end
            step();
        end
        gnt_bus = '0;
        step();
        vectors++;
        if (free_count !== 5'd16) begin miscompares++; $display("FAIL drain_free_count: got %0d expected 16", free_count); end
        vectors++;
        if (iss_valid !== 3'b000) begin miscompares++; $display("FAIL drain_iss_valid: got %b expected 000", iss_valid); end
    endtask

    task automatic test_multi_issue();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            set_disp(6'd1, 1'b1, 6'd2, 1'b1, 6'(20 + i), 32'hA000_0000 + 32'(i), i);
            step();
        end
        disp_valid = 1'b0;
        vectors++;
        if (free_count !== 5'd8) begin miscompares++; $display("FAIL multi_pre_free_count: got %0d expected 8", free_count); end
        vectors++;
        if (req !== 16'h00FF) begin miscompares++; $display("FAIL multi_pre_req: got %h expected 00ff", req); end
        grant(0, 0, 1'b1);
        grant(1, 7, 1'b1);
        grant(2, 3, 1'b1);
        step();
        gnt_bus = '0;
        vectors++;
        if (iss_valid !== 3'b111) begin miscompares++; $display("FAIL multi_iss_valid: got %b expected 111", iss_valid); end
        vectors++;
        if (free_count !== 5'd11) begin miscompares++; $display("FAIL multi_free_count: got %0d expected 11", free_count); end
        vectors++;
        if (req !== 16'h0076) begin miscompares++; $display("FAIL multi_req: got %h expected 0076", req); end
        step();
        vectors++;
        if (iss_valid !== 3'b000) begin miscompares++; $display("FAIL multi_idle_iss_valid: got %b expected 000", iss_valid); end
    endtask

    task automatic test_bad_grants();
        grant(0, 9, 1'b0);
        grant(1, 1, 1'b1);
        step();
        gnt_bus = '0;
        vectors++;
        if (iss_valid !== 3'b010) begin miscompares++; $display("FAIL invalid_grant_iss_valid: got %b expected 010", iss_valid); end
        vectors++;
        if (free_count !== 5'd12) begin miscompares++; $display("FAIL invalid_grant_free_count: got %0d expected 12", free_count); end
        grant(0, 2, 1'b1);
        grant(2, 2, 1'b0);
        step();
        gnt_bus = '0;
        vectors++;
        if (iss_valid !== 3'b001) begin miscompares++; $display("FAIL dup_grant_iss_valid: got %b expected 001", iss_valid); end
        vectors++;
        if (free_count !== 5'd13) begin miscompares++; $display("FAIL dup_grant_free_count: got %0d expected 13", free_count); end
        vectors++;
        if (req !== 16'h0070) begin miscompares++; $display("FAIL dup_grant_req: got %h expected 0070", req); end
    endtask

    task automatic test_wakeup();
        do_reset();
        set_disp(6'd5, 1'b0, 6'd9, 1'b1, 6'd33, 32'h5555_0005, 0);
        step();
        disp_valid = 1'b0;
        vectors++;
        if (req !== 16'h0) begin miscompares++; $display("FAIL wake_pre_req: got %h expected 0000", req); end
        cdb_valid = 2'b10;
        cdb_tag   = {6'd5, 6'd0};
        #1;
`ifdef RS_CDB_BYPASS_EN
        vectors++;
        if (req !== 16'h1) begin miscompares++; $display("FAIL wake_bypass_req: got %h expected 0001", req); end
        grant(0, 0, 1'b1);
        step();
        idle_inputs();
`else
        vectors++;
        if (req !== 16'h0) begin miscompares++; $display("FAIL wake_same_cycle_req: got %h expected 0000", req); end
        step();
        idle_inputs();
        vectors++;
        if (req !== 16'h1) begin miscompares++; $display("FAIL wake_req: got %h expected 0001", req); end
        vectors++;
        if (iss_valid !== 3'b000) begin miscompares++; $display("FAIL wake_early_issue: got %b expected 000", iss_valid); end
        grant(0, 0, 1'b1);
        step();
        gnt_bus = '0;
`endif
        vectors++;
        if (iss_valid !== 3'b001) begin miscompares++; $display("FAIL wake_iss_valid: got %b expected 001", iss_valid); end
        vectors++;
        if (free_count !== 5'd16) begin miscompares++; $display("FAIL wake_free_count: got %0d expected 16", free_count); end
        set_disp(6'd11, 1'b0, 6'd12, 1'b0, 6'd34, 32'h5555_0011, 0);
        step();
        disp_valid = 1'b0;
        cdb_valid  = 2'b01;
        cdb_tag    = {6'd0, 6'd11};
        step();
        idle_inputs();
        vectors++;
        if (req !== 16'h0) begin miscompares++; $display("FAIL wake_half_req: got %h expected 0000", req); end
        step();
        cdb_valid = 2'b10;
        cdb_tag   = {6'd12, 6'd0};
        step();
        idle_inputs();
        vectors++;
        if (req !== 16'h1) begin miscompares++; $display("FAIL wake_sticky_req: got %h expected 0001", req); end
        grant(0, 0, 1'b1);
        step();
        gnt_bus = '0;
        vectors++;
        if (iss_valid !== 3'b001) begin miscompares++; $display("FAIL wake_sticky_iss: got %b expected 001", iss_valid); end
    endtask

    task automatic test_disp_bypass();
        do_reset();
        set_disp(6'd40, 1'b0, 6'd41, 1'b0, 6'd35, 32'hB0B0_0040, 0);
        cdb_valid = 2'b11;
        cdb_tag   = {6'd41, 6'd40};
        step();
        idle_inputs();
        vectors++;
        if (req !== 16'h1) begin miscompares++; $display("FAIL disp_cdb_req: got %h expected 0001", req); end
        set_disp(6'd50, 1'b0, 6'd51, 1'b1, 6'd36, 32'hB0B0_0050, 1);
        cdb_valid = 2'b00;
        cdb_tag   = {6'd0, 6'd50};
        step();
        idle_inputs();
        vectors++;
        if (req !== 16'h1) begin miscompares++; $display("FAIL disp_cdb_invalid_lane_req: got %h expected 0001", req); end
        grant(0, 0, 1'b1);
        step();
        gnt_bus = '0;
        vectors++;
        if (iss_valid !== 3'b001) begin miscompares++; $display("FAIL disp_cdb_iss_valid: got %b expected 001", iss_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        set_disp(6'd1, 1'b1, 6'd2, 1'b1, 6'd1, 32'hB2B0_0000, 0);
        step();
        set_disp(6'd1, 1'b1, 6'd2, 1'b1, 6'd2, 32'hB2B0_0001, 1);
        grant(0, 0, 1'b1);
        step();
        idle_inputs();
        vectors++;
        if (iss_valid !== 3'b001) begin miscompares++; $display("FAIL b2b_iss_valid: got %b expected 001", iss_valid); end
        vectors++;
        if (req !== 16'h0002) begin miscompares++; $display("FAIL b2b_req: got %h expected 0002", req); end
        vectors++;
        if (free_count !== 5'd15) begin miscompares++; $display("FAIL b2b_free_count: got %0d expected 15", free_count); end
        grant(1, 1, 1'b1);
        step();
        gnt_bus = '0;
        vectors++;
        if (iss_valid !== 3'b010) begin miscompares++; $display("FAIL b2b_second_iss_valid: got %b expected 010", iss_valid); end
    endtask

    task automatic test_flush();
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            for (int i = 0; i < 10; i++) begin
                set_disp(6'd3, 1'b1, 6'd4, 1'b1, 6'(40 + i), 32'hC000_0000 + 32'(i), i);
                step();
            end
            disp_valid = 1'b0;
            vectors++;
            if (free_count !== 5'd6) begin miscompares++; $display("FAIL squash%0d_pre_free_count: got %0d expected 6", pass, free_count); end
            if (pass == 0) flush = 1'b1;
            else           reset = 1'b0;
            grant(0, 0, 1'b0);
            grant(1, 1, 1'b0);
            set_disp(6'd3, 1'b1, 6'd4, 1'b1, 6'd62, 32'hDEAD_0000, -1);
            #1;
            vectors++;
            if (sel_en !== 1'b0) begin miscompares++; $display("FAIL squash%0d_sel_en: got %b expected 0", pass, sel_en); end
            step();
            reset = 1'b1;
            idle_inputs();
            vectors++;
            if (free_count !== 5'd16) begin miscompares++; $display("FAIL squash%0d_free_count: got %0d expected 16", pass, free_count); end
            vectors++;
            if (iss_valid !== 3'b000) begin miscompares++; $display("FAIL squash%0d_iss_valid: got %b expected 000", pass, iss_valid); end
            vectors++;
            if (req !== 16'h0) begin miscompares++; $display("FAIL squash%0d_req: got %h expected 0000", pass, req); end
            step();
            vectors++;
            if (free_count !== 5'd16 || disp_ready !== 1'b1) begin
                miscompares++;
                $display("FAIL squash%0d_after: got free %0d ready %b expected 16 1", pass, free_count, disp_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_multi_issue();
        test_bad_grants();
        test_wakeup();
        test_disp_bypass();
        test_back_to_back();
        test_flush();
        step();
        step();
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending issues expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
